// File: rtl/tff_pkg.sv
// Shared types and helpers for the toggle-cell counter: modulo arithmetic,
// load clamping and the legal-parameter check.
package tff_pkg;

  localparam int MAX_WIDTH = 32;

  // One spare bit so q+1 and a modulus of 2**32 are both representable.
  typedef logic [MAX_WIDTH:0] wide_t;

  function automatic wide_t clamp_mod(wide_t value, wide_t modulus);
    return (value >= modulus) ? modulus - wide_t'(1) : value;
  endfunction

  // Result is {wrap, next}.
  function automatic logic [MAX_WIDTH+1:0] next_count(wide_t q, logic up, wide_t modulus);
    wide_t last;
    wide_t nxt;
    logic  wrap;
    last = modulus - wide_t'(1);
    wrap = 1'b0;
    if (up) begin
      if (q == last) begin
        nxt  = '0;
        wrap = 1'b1;
      end else begin
        nxt = q + wide_t'(1);
      end
    end else begin
      if (q == '0) begin
        nxt  = last;
        wrap = 1'b1;
      end else begin
        nxt = q - wide_t'(1);
      end
    end
    return {wrap, nxt};
  endfunction

  function automatic bit params_ok(int width, longint modulus, longint reset_val);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (modulus >= 2) && (modulus <= (longint'(1) << width)) &&
           (reset_val >= 0) && (reset_val < modulus);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with asynchronous reset to a per-instance value.
module tff_cell #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic T,
  output logic Q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q <= INIT;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// Modulo-N up/down counter whose state lives in a bank of toggle cells;
// clear, load and count all reach the cells through their toggle inputs.
module tff_counter
  import tff_pkg::*;
#(
  parameter int     WIDTH     = 8,
  parameter longint MODULUS   = longint'(1) << WIDTH,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);

  localparam wide_t MOD_W = wide_t'(MODULUS);

  generate
    if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_param_check
      $error("tff_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end
  endgenerate

  logic [WIDTH-1:0]       next_q;
  logic [WIDTH-1:0]       toggle;
  logic                   wrap_ev;
  logic [MAX_WIDTH+1:0]   count_res;
  wide_t                  load_clamped;
  logic                   unused_bits;

  // Priority clr > load > en; only a count can produce a wrap event.
  always_comb begin
    count_res    = next_count(wide_t'(q), up, MOD_W);
    load_clamped = clamp_mod(wide_t'(load_val), MOD_W);
    next_q       = q;
    wrap_ev      = 1'b0;
    if (clr) begin
      next_q = '0;
    end else if (load) begin
      next_q = load_clamped[WIDTH-1:0];
    end else if (en) begin
      next_q  = count_res[WIDTH-1:0];
      wrap_ev = count_res[MAX_WIDTH+1];
    end
  end

  assign unused_bits = ^{count_res[MAX_WIDTH:WIDTH], load_clamped[MAX_WIDTH:WIDTH]};
  assign toggle      = q ^ next_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cells
      tff_cell #(.INIT(RESET_VAL[i])) u_cell (
        .clk   (clk),
        .reset (reset),
        .T     (toggle[i]),
        .Q     (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      tc <= wrap_ev;
      if (clr) begin
        wrapped <= 1'b0;
      end else if (wrap_ev) begin
        wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: a decimal counter, a full-range 4-bit
// counter and a modulo-2 counter sharing one set of stimulus inputs.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       reset, clr, load, en, up;
  logic [3:0] lv;
  logic [3:0] q_a, q_b;
  logic [0:0] q_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrapped_a, wrapped_b, wrapped_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv),
    .en(en), .up(up), .q(q_a), .tc(tc_a), .wrapped(wrapped_a)
  );

  tff_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv),
    .en(en), .up(up), .q(q_b), .tc(tc_b), .wrapped(wrapped_b)
  );

  tff_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(0)) dut_c (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(lv[0:0]),
    .en(en), .up(up), .q(q_c), .tc(tc_c), .wrapped(wrapped_c)
  );

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_c[4]   = '{1, 0, 1, 0};
  int exp_tc_c[4] = '{0, 1, 0, 1};

  initial begin
    reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; lv = 4'd0;

    // Reset takes effect before any clock edge.
    #2;
    check_output("rst_q", 32'(q_a), 3);
    check_output("rst_tc", 32'(tc_a), 0);
    check_output("rst_wrapped", 32'(wrapped_a), 0);
    check_output("rst_q_b", 32'(q_b), 0);
    #1 reset = 1'b0;
    repeat (5) apply_stimulus();
    check_output("idle_q", 32'(q_a), 3);

    clr = 1'b1;
    apply_stimulus();
    clr = 1'b0;
    check_output("clr_q", 32'(q_a), 0);
    check_output("clr_wrapped", 32'(wrapped_a), 0);

    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus();
      check_output($sformatf("up_q%0d", i), 32'(q_a), 32'(exp_up[i]));
      check_output($sformatf("up_tc%0d", i), 32'(tc_a), (i == 9) ? 1 : 0);
      check_output($sformatf("up_wr%0d", i), 32'(wrapped_a), (i >= 9) ? 1 : 0);
    end

    en = 1'b0; load = 1'b1; lv = 4'd1;
    apply_stimulus();
    check_output("ld1_q", 32'(q_a), 1);
    check_output("ld1_wrapped", 32'(wrapped_a), 1);
    check_output("ld1_q_b", 32'(q_b), 1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    apply_stimulus();
    check_output("dn_q0", 32'(q_a), 0);
    check_output("dn_tc0", 32'(tc_a), 0);
    apply_stimulus();
    check_output("dn_q9", 32'(q_a), 9);
    check_output("dn_tc9", 32'(tc_a), 1);
    check_output("full_q15", 32'(q_b), 15);
    check_output("full_tc", 32'(tc_b), 1);
    check_output("full_wrapped", 32'(wrapped_b), 1);
    apply_stimulus();
    check_output("dn_q8", 32'(q_a), 8);
    check_output("dn_tc8", 32'(tc_a), 0);
    check_output("full_q14", 32'(q_b), 14);

    en = 1'b0; load = 1'b1; lv = 4'd13;
    apply_stimulus();
    check_output("clamp_q", 32'(q_a), 9);
    check_output("clamp_tc", 32'(tc_a), 0);
    check_output("clamp_wrapped", 32'(wrapped_a), 1);
    clr = 1'b1; en = 1'b1; up = 1'b1;
    apply_stimulus();
    check_output("prio_q", 32'(q_a), 0);
    check_output("prio_wrapped", 32'(wrapped_a), 0);
    check_output("prio_tc", 32'(tc_a), 0);
    clr = 1'b0; en = 1'b0; lv = 4'd9;
    apply_stimulus();
    en = 1'b1; lv = 4'd0;
    apply_stimulus();
    check_output("ldwrap_q", 32'(q_a), 0);
    check_output("ldwrap_tc", 32'(tc_a), 0);
    check_output("ldwrap_wrapped", 32'(wrapped_a), 0);

    // Wrap once so the async reset has a set sticky flag to clear.
    en = 1'b0; lv = 4'd9;
    apply_stimulus();
    load = 1'b0; en = 1'b1; up = 1'b1;
    apply_stimulus();
    check_output("pre_q", 32'(q_a), 0);
    check_output("pre_tc", 32'(tc_a), 1);
    load = 1'b1; lv = 4'd9;
    apply_stimulus();
    check_output("pre_q9", 32'(q_a), 9);
    check_output("pre_wrapped", 32'(wrapped_a), 1);
    load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("arst_q", 32'(q_a), 3);
    check_output("arst_tc", 32'(tc_a), 0);
    check_output("arst_wrapped", 32'(wrapped_a), 0);
    apply_stimulus();
    check_output("arst_hold_q", 32'(q_a), 3);
    check_output("arst_hold_tc", 32'(tc_a), 0);
    reset = 1'b0;
    apply_stimulus();
    check_output("resume_q", 32'(q_a), 4);
    check_output("resume_tc", 32'(tc_a), 0);

    en = 1'b0; up = 1'b0;
    apply_stimulus();
    check_output("hold_q0", 32'(q_a), 4);
    up = 1'b1;
    apply_stimulus();
    check_output("hold_q1", 32'(q_a), 4);
    check_output("hold_tc", 32'(tc_a), 0);

    clr = 1'b1;
    apply_stimulus();
    clr = 1'b0;
    check_output("m2_clr_q", 32'(q_c), 0);
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus();
      check_output($sformatf("m2_q%0d", i), 32'(q_c), 32'(exp_c[i]));
      check_output($sformatf("m2_tc%0d", i), 32'(tc_c), 32'(exp_tc_c[i]));
    end
    check_output("m2_wrapped", 32'(wrapped_c), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
